// File: rtl/input_pkg.sv
// input_pkg: shared channel state encoding and counter width helper for the debounce block.
package input_pkg;
  typedef enum logic [2:0] {IDLE, ARM, HELD, REPEAT, DISARM} chan_state_t;
  function automatic int cw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one input channel -- 2-FF synchronizer, debounce/auto-repeat FSM, registered strobes.
module debounce_chan
  import input_pkg::*;
#(
  parameter int DEB_TICKS  = 10,
  parameter int REP_DELAY  = 300,
  parameter int REP_PERIOD = 50
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt,
  output logic move
);
  localparam int DW = cw(DEB_TICKS);
  localparam int RW = cw(REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD);
  localparam logic [DW-1:0] D_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REP_PERIOD - 1);
  logic [1:0] sync;
  logic s_in;
  chan_state_t st, nxt;
  logic [DW-1:0] dcnt, dn;
  logic [RW-1:0] rcnt, rn;
  logic p, r, rp;
  assign s_in = sync[1];
  // A change in s_in always takes priority over a tick in the same cycle.
  always_comb begin
    nxt = st;
    dn = dcnt;
    rn = rcnt;
    p = 1'b0;
    r = 1'b0;
    rp = 1'b0;
    if (!enable) begin
      nxt = IDLE;
      dn = '0;
      rn = '0;
    end else begin
      case (st)
        IDLE: if (s_in) begin nxt = ARM; dn = '0; end
        ARM:
          if (!s_in) nxt = IDLE;
          else if (tick) begin
            if (dcnt == D_LAST) begin nxt = HELD; p = 1'b1; rn = '0; end
            else dn = dcnt + 1'b1;
          end
        HELD, REPEAT:
          if (!s_in) begin nxt = DISARM; dn = '0; end
          else if (tick) begin
            if (rcnt == (st == HELD ? RD_LAST : RP_LAST)) begin nxt = REPEAT; rp = 1'b1; rn = '0; end
            else rn = rcnt + 1'b1;
          end
        DISARM:
          if (s_in) begin nxt = HELD; rn = '0; end
          else if (tick) begin
            if (dcnt == D_LAST) begin nxt = IDLE; r = 1'b1; end
            else dn = dcnt + 1'b1;
          end
        default: nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync <= '0;
      st <= IDLE;
      dcnt <= '0;
      rcnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      rpt <= 1'b0;
      move <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      st <= nxt;
      dcnt <= dn;
      rcnt <= rn;
      level <= nxt inside {HELD, REPEAT, DISARM};
      press <= p;
      rel <= r;
      rpt <= rp;
      move <= p | rp;
    end
  end
endmodule

// File: rtl/input_debounce_ctrl.sv
// input_debounce_ctrl: shared tick prescaler feeding N_CH independent debounce/auto-repeat channels.
module input_debounce_ctrl
  import input_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEB_TICKS  = 10,
  parameter int REP_DELAY  = 300,
  parameter int REP_PERIOD = 50
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            enable,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat,
  output logic [N_CH-1:0] move_strobe,
  output logic            tick
);
  localparam int PW = cw(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  logic [PW-1:0] pcnt;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pcnt <= '0;
    else pcnt <= (!enable || pcnt == P_LAST) ? '0 : pcnt + 1'b1;
  end
  assign tick = enable && pcnt == P_LAST;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_chan #(
      .DEB_TICKS (DEB_TICKS),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD)
    ) u_chan (
      .Clk    (Clk),
      .Reset_n(Reset_n),
      .enable (enable),
      .tick   (tick),
      .raw    (raw_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .rpt    (btn_repeat[i]),
      .move   (move_strobe[i])
    );
  end
endmodule

// File: tb/tb_input_debounce_ctrl.sv
// tb_input_debounce_ctrl: directed and random stimulus checked against a stability/tick-count reference model.
module tb_input_debounce_ctrl;
  localparam int N = 4, TD = 4, DEB = 3, RD = 5, RP = 2;
  logic Clk = 1'b0, Reset_n = 1'b0, enable = 1'b1;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat, move_strobe;
  logic tick;
  int tests = 0, fails = 0;
  bit L[N], dis[N], s1[N], s2[N];
  int stab[N], ht[N], cnt;
  logic [N-1:0] e_level, e_press, e_rel, e_rpt;
  logic e_tick;
  bit all_pressed;
  int rel2, press2;
  input_debounce_ctrl #(
    .N_CH(N), .TICK_DIV(TD), .DEB_TICKS(DEB), .REP_DELAY(RD), .REP_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .raw_in(raw_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .move_strobe(move_strobe), .tick(tick)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      L[c] = 0; dis[c] = 0; s1[c] = 0; s2[c] = 0; stab[c] = 0; ht[c] = 0;
    end
    cnt = 0;
  endtask
  // Level flips once the synced input has disagreed with it for DEB whole ticks;
  // repeats fire at RD, RD+RP, RD+2RP... ticks of uninterrupted agreement after a press.
  task automatic model_eval();
    bit tk;
    tk = enable && cnt == TD - 1;
    e_press = '0; e_rel = '0; e_rpt = '0;
    for (int c = 0; c < N; c++) begin
      if (!enable) begin
        L[c] = 0; dis[c] = 0;
      end else if (s2[c] != L[c]) begin
        if (!dis[c]) begin dis[c] = 1; stab[c] = 0; end
        else if (tk) begin
          stab[c]++;
          if (stab[c] == DEB) begin
            L[c] = s2[c]; dis[c] = 0;
            if (L[c]) begin e_press[c] = 1; ht[c] = 0; end
            else e_rel[c] = 1;
          end
        end
      end else if (dis[c]) begin
        dis[c] = 0;
        if (L[c]) ht[c] = 0;
      end else if (L[c] && tk) begin
        ht[c]++;
        if (ht[c] >= RD && (ht[c] - RD) % RP == 0) e_rpt[c] = 1;
      end
      e_level[c] = L[c];
      s2[c] = s1[c]; s1[c] = raw_in[c];
    end
    cnt = enable ? (cnt + 1) % TD : 0;
    e_tick = enable && cnt == TD - 1;
  endtask
  task automatic step();
    model_eval();
    @(posedge Clk);
    #1;
    check("level", 32'(btn_level), 32'(e_level));
    check("press", 32'(btn_press), 32'(e_press));
    check("release", 32'(btn_release), 32'(e_rel));
    check("repeat", 32'(btn_repeat), 32'(e_rpt));
    check("move", 32'(move_strobe), 32'(e_press | e_rpt));
    check("tick", 32'(tick), 32'(e_tick));
    if (btn_press == 4'hF) all_pressed = 1;
    rel2 += int'(btn_release[2]);
    press2 += int'(btn_press[2]);
  endtask
  task automatic run(input logic [N-1:0] r, input int n);
    raw_in = r;
    repeat (n) step();
  endtask
  initial begin
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("rst_outputs", {btn_level, btn_press, btn_release, btn_repeat, move_strobe, 3'b0, tick}, 0);
    Reset_n = 1'b1;
    run(4'h0, 8);
    run(4'h1, 60);
    run(4'h0, 24);
    for (int k = 0; k < 10; k++) run(k[0] ? 4'h0 : 4'h2, 3);
    run(4'h2, 40);
    run(4'h0, 5);
    run(4'h2, 50);
    run(4'h0, 24);
    all_pressed = 0;
    run(4'hF, 24);
    check("sim_all_press", 32'(all_pressed), 1);
    run(4'h0, 24);
    run(4'h4, 24);
    rel2 = 0;
    enable = 1'b0;
    run(4'h4, 2);
    check("en_no_release", 32'(rel2), 0);
    check("en_level_clear", 32'(btn_level[2]), 0);
    enable = 1'b1;
    press2 = 0;
    run(4'h4, 24);
    check("en_fresh_press", 32'(press2), 1);
    run(4'hF, 30);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst", {btn_level, btn_press, btn_release, btn_repeat, move_strobe, 3'b0, tick}, 0);
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    run(4'hF, 40);
    for (int seg = 0; seg < 60; seg++) begin
      enable = $urandom_range(0, 9) != 0;
      run(4'($urandom), $urandom_range(1, 60));
    end
    enable = 1'b1;
    run(4'h0, 30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
